// File: rtl/enc_pkg.sv
// Shared state encodings and quadrature transition decode for the encoder front end.
package enc_pkg;

   localparam logic [1:0] ENC_S00 = 2'b00;
   localparam logic [1:0] ENC_S01 = 2'b01;
   localparam logic [1:0] ENC_S11 = 2'b11;
   localparam logic [1:0] ENC_S10 = 2'b10;

   typedef enum logic [1:0] {
      ST_00 = ENC_S00,
      ST_01 = ENC_S01,
      ST_11 = ENC_S11,
      ST_10 = ENC_S10
   } enc_state_t;

   // Returns {legal, fwd}: legal when exactly one channel changed, fwd for the 00->01->11->10 order.
   function automatic logic [1:0] enc_dir(input logic [1:0] prev, input logic [1:0] cur);
      logic legal;
      logic fwd;
      legal = ^(prev ^ cur);
      case (prev)
         ENC_S00: fwd = (cur == ENC_S01);
         ENC_S01: fwd = (cur == ENC_S11);
         ENC_S11: fwd = (cur == ENC_S10);
         default: fwd = (cur == ENC_S00);
      endcase
      return {legal, fwd & legal};
   endfunction

endpackage

// File: rtl/quad_encoder_frontend_if.sv
// Encoder pin inputs, control strobes and decoded outputs of the encoder front end.
interface quad_encoder_frontend_if #(
   parameter int unsigned POS_W = 16
);
   logic             enc_a;
   logic             enc_b;
   logic             clr_pos;
   logic             clr_err;
   logic             ticks;
   logic             step;
   logic             dir;
   logic [POS_W-1:0] pos;
   logic             err;
   logic             ready;

   modport master (
      output enc_a, enc_b, clr_pos, clr_err,
      input  ticks, step, dir, pos, err, ready
   );

   modport slave (
      input  enc_a, enc_b, clr_pos, clr_err,
      output ticks, step, dir, pos, err, ready
   );
endinterface

// File: rtl/enc_glitch_filter.sv
// Per-channel glitch filter: output follows a synchronised input only after FILT_LEN stable cycles.
module enc_glitch_filter #(
   parameter int unsigned FILT_LEN = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic din_sync,
   output logic dout
);

   localparam int unsigned       CNT_W    = $clog2(FILT_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILT_LEN - 1);

   logic [CNT_W-1:0] cnt;

   // Count consecutive differing cycles; accept the new level on the FILT_LEN-th one.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (din_sync != dout) begin
         if (cnt == CNT_LAST) begin
            dout <= din_sync;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/quad_encoder_frontend.sv
// Quadrature encoder front end: synchronise, glitch-filter and x4-decode channels A/B.
module quad_encoder_frontend
   import enc_pkg::*;
#(
   parameter int unsigned FILT_LEN = 4,
   parameter int unsigned POS_W    = 16
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   quad_encoder_frontend_if.slave  bus
);

   localparam int unsigned      SU_W    = $clog2(FILT_LEN + 3);
   localparam logic [SU_W-1:0]  SU_LAST = SU_W'(FILT_LEN + 2);

   logic a_meta, a_sync, b_meta, b_sync;
   logic filt_a, filt_b;

   enc_state_t       state_q, state_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             err_q, err_d;
   logic             ready_q, ready_d;
   logic             ticks_q, ticks_d;
   logic [SU_W-1:0]  su_q, su_d;
   logic [1:0]       cur;
   logic [1:0]       dec;

   // Two-flop synchronisers for the asynchronous encoder pins.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         a_meta <= 1'b0;
         a_sync <= 1'b0;
         b_meta <= 1'b0;
         b_sync <= 1'b0;
      end else begin
         a_meta <= bus.enc_a;
         a_sync <= a_meta;
         b_meta <= bus.enc_b;
         b_sync <= b_meta;
      end
   end

   enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .din_sync (a_sync),
      .dout     (filt_a)
   );

   enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .din_sync (b_sync),
      .dout     (filt_b)
   );

   assign cur = {filt_a, filt_b};

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_00;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         pos_q   <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         ticks_q <= 1'b0;
         su_q    <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         pos_q   <= pos_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         ticks_q <= ticks_d;
         su_q    <= su_d;
      end
   end

   // Next state: track filtered pair, decode edges once seeded; clears lose to a new fault, win over a step.
   always_comb begin
      state_d = enc_state_t'(cur);
      step_d  = 1'b0;
      dir_d   = dir_q;
      pos_d   = pos_q;
      err_d   = err_q & ~bus.clr_err;
      ready_d = ready_q;
      ticks_d = filt_a;
      su_d    = su_q;
      dec     = enc_dir(state_q, cur);

      if (!ready_q) begin
         if (su_q == SU_LAST) begin
            ready_d = 1'b1;
         end else begin
            su_d = su_q + SU_W'(1);
         end
      end else if (state_q != cur) begin
         if (dec[1]) begin
            step_d = 1'b1;
            dir_d  = dec[0];
            pos_d  = dec[0] ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
         end else begin
            err_d = 1'b1;
         end
      end

      if (bus.clr_pos) begin
         pos_d = '0;
      end
   end

   assign bus.ticks = ticks_q;
   assign bus.step  = step_q;
   assign bus.dir   = dir_q;
   assign bus.pos   = pos_q;
   assign bus.err   = err_q;
   assign bus.ready = ready_q;

endmodule

// File: tb/tb_quad_encoder_frontend.sv
// Directed bench for quad_encoder_frontend with FILT_LEN=4, POS_W=16.
module tb_quad_encoder_frontend;

   logic CLK;
   logic RST_N;
   int   total;
   int   bad;
   int   step_cnt;
   int   snap;

   quad_encoder_frontend_if #(.POS_W(16)) bus ();

   quad_encoder_frontend #(.FILT_LEN(4), .POS_W(16)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Count step pulses; each pulse spans exactly one falling edge.
   always @(negedge CLK) begin
      if (RST_N && bus.step === 1'b1) step_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   task automatic set_ab(input logic a, input logic b);
      bus.enc_a = a;
      bus.enc_b = b;
   endtask

   task automatic do_reset(input logic a, input logic b);
      RST_N = 1'b0;
      set_ab(a, b);
      hold(3);
      RST_N = 1'b1;
      hold(12);
   endtask

   initial begin
      logic [1:0] seq [0:3];
      total        = 0;
      bad          = 0;
      step_cnt     = 0;
      RST_N        = 1'b0;
      bus.clr_pos  = 1'b0;
      bus.clr_err  = 1'b0;
      set_ab(1'b1, 1'b1);
      hold(3);

      // 1: reset values, then startup with inputs held at 11
      chk("rst_ticks", 32'(bus.ticks), 32'd0);
      chk("rst_step",  32'(bus.step),  32'd0);
      chk("rst_dir",   32'(bus.dir),   32'd0);
      chk("rst_pos",   32'(bus.pos),   32'd0);
      chk("rst_err",   32'(bus.err),   32'd0);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      RST_N = 1'b1;
      hold(6);
      chk("ready_c6", 32'(bus.ready), 32'd0);
      tick();
      chk("ready_c7", 32'(bus.ready), 32'd1);
      hold(13);
      chk("s1_steps", 32'(step_cnt), 32'd0);
      chk("s1_err",   32'(bus.err),   32'd0);
      chk("s1_pos",   32'(bus.pos),   32'd0);
      chk("s1_ticks", 32'(bus.ticks), 32'd1);

      // 2: forward sequence from 00
      do_reset(1'b0, 1'b0);
      snap = step_cnt;
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         set_ab(seq[i][1], seq[i][0]);
         hold(10);
         chk("fwd_ticks", 32'(bus.ticks), 32'(seq[i][1]));
      end
      chk("fwd_steps", 32'(step_cnt - snap), 32'd4);
      chk("fwd_dir",   32'(bus.dir), 32'd1);
      chk("fwd_pos",   32'(bus.pos), 32'd4);
      chk("fwd_err",   32'(bus.err), 32'd0);

      // 3: reverse sequence twice, wrapping through zero
      snap = step_cnt;
      seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            set_ab(seq[i][1], seq[i][0]);
            hold(10);
         end
      end
      chk("rev_steps", 32'(step_cnt - snap), 32'd8);
      chk("rev_dir",   32'(bus.dir), 32'd0);
      chk("rev_pos",   32'(bus.pos), 32'hFFFC);

      // 4: 3-cycle glitch rejected, 4-cycle pulse accepted with fixed latency
      snap = step_cnt;
      bus.enc_a = 1'b1;
      hold(3);
      bus.enc_a = 1'b0;
      hold(15);
      chk("glitch_steps", 32'(step_cnt - snap), 32'd0);
      chk("glitch_ticks", 32'(bus.ticks), 32'd0);
      bus.enc_a = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 4) bus.enc_a = 1'b0;
         if (c == 6) chk("pulse_step_c6", 32'(bus.step), 32'd0);
         if (c == 7) chk("pulse_step_c7", 32'(bus.step), 32'd1);
         if (c == 7) chk("pulse_ticks_c7", 32'(bus.ticks), 32'd1);
      end
      #5;
      chk("pulse_one_step", 32'(step_cnt - snap), 32'd1);
      hold(10);
      chk("pulse_pos", 32'(bus.pos), 32'hFFFC);
      chk("pulse_dir", 32'(bus.dir), 32'd1);

      // 5: illegal double-bit transitions and err clear priority
      snap = step_cnt;
      set_ab(1'b1, 1'b1);
      hold(10);
      chk("ill_err",   32'(bus.err), 32'd1);
      chk("ill_pos",   32'(bus.pos), 32'hFFFC);
      chk("ill_steps", 32'(step_cnt - snap), 32'd0);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("clr_err", 32'(bus.err), 32'd0);
      set_ab(1'b0, 1'b0);
      hold(6);
      chk("pre_fault_err", 32'(bus.err), 32'd0);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("set_wins_err", 32'(bus.err), 32'd1);
      hold(3);
      chk("err_sticky", 32'(bus.err), 32'd1);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;

      // 6: wrap at 0xFFFF, clr_pos vs step, reset mid-run
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
      for (int i = 0; i < 3; i++) begin
         set_ab(seq[i][1], seq[i][0]);
         hold(10);
      end
      chk("pos_ffff", 32'(bus.pos), 32'hFFFF);
      set_ab(1'b0, 1'b0);
      hold(10);
      chk("pos_wrap0", 32'(bus.pos), 32'd0);
      set_ab(1'b0, 1'b1);
      hold(6);
      bus.clr_pos = 1'b1;
      tick();
      bus.clr_pos = 1'b0;
      chk("clrpos_step", 32'(bus.step), 32'd1);
      chk("clrpos_pos",  32'(bus.pos),  32'd0);
      chk("clrpos_dir",  32'(bus.dir),  32'd1);
      set_ab(1'b1, 1'b1);
      hold(10);
      chk("pre_rst_pos", 32'(bus.pos), 32'd1);
      set_ab(1'b1, 1'b0);
      hold(4);
      RST_N = 1'b0;
      #2;
      chk("mid_rst_ticks", 32'(bus.ticks), 32'd0);
      chk("mid_rst_dir",   32'(bus.dir),   32'd0);
      chk("mid_rst_pos",   32'(bus.pos),   32'd0);
      chk("mid_rst_err",   32'(bus.err),   32'd0);
      chk("mid_rst_step",  32'(bus.step),  32'd0);
      chk("mid_rst_ready", 32'(bus.ready), 32'd0);
      hold(2);
      RST_N = 1'b1;
      hold(3);
      chk("restart_ready_lo", 32'(bus.ready), 32'd0);
      hold(4);
      chk("restart_ready_hi", 32'(bus.ready), 32'd1);
      chk("restart_err",      32'(bus.err),   32'd0);
      chk("restart_pos",      32'(bus.pos),   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
